// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture controller.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } la_state_e;

    localparam logic [1:0] TRIG_LEVEL = 2'b00;
    localparam logic [1:0] TRIG_RISE  = 2'b01;
    localparam logic [1:0] TRIG_FORCE = 2'b10;

    // True while samples are being taken and written to the ring.
    function automatic logic state_active(la_state_e s);
        return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Write port towards the circular capture RAM.
interface la_capture_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/la_trig_match.sv
// Trigger evaluation: latched mask/value/mode, match of the current sample,
// and the previous-sample match used for rising-edge detection.
module la_trig_match
    import la_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,      // capture accepted: latch settings
    input  logic [DATA_W-1:0] mask_in,
    input  logic [DATA_W-1:0] val_in,
    input  logic [1:0]        mode_in,
    input  logic              sample,    // a sample is being taken this cycle
    input  logic [DATA_W-1:0] probe,
    output logic              fire
);

    logic [DATA_W-1:0] mask_l;
    logic [DATA_W-1:0] val_l;
    logic [1:0]        mode_l;
    logic              prev_match;
    logic              match;

    assign match = ((probe ^ val_l) & mask_l) == '0;

    // Trigger decision for the current sample; mode 11 behaves as level.
    always_comb begin
        fire = match;
        case (mode_l)
            TRIG_RISE:  fire = match & ~prev_match;
            TRIG_FORCE: fire = 1'b1;
            default:    fire = match;
        endcase
    end

    // Settings latch on arm; prev_match starts high so a channel already
    // matching at arm does not count as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_l     <= '0;
            val_l      <= '0;
            mode_l     <= TRIG_LEVEL;
            prev_match <= 1'b1;
        end else if (load) begin
            mask_l     <= mask_in;
            val_l      <= val_in;
            mode_l     <= mode_in;
            prev_match <= 1'b1;
        end else if (sample) begin
            prev_match <= match;
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: drives the sample-clock divider, writes each sample
// into a circular RAM, waits for the trigger and stops after post_len
// further samples, reporting trigger and pre-window start addresses.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_bps,
    output logic              bps_start,
    input  logic [DATA_W-1:0] probe_in,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_val,
    input  logic [1:0]        trig_mode,
    la_capture_ctrl_if.master wr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    la_state_e         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_l;
    logic [ADDR_W-1:0] post_l;
    logic              arm_ok;
    logic              sample;
    logic              fire;
    logic [ADDR_W:0]   len_sum;
    logic [ADDR_W-1:0] post_clamped;

    assign arm_ok = arm & ~abort & ((state == ST_IDLE) || (state == ST_DONE));
    assign sample = clk_bps & ~abort & state_active(state);

    // pre + post must fit in the ring alongside the trigger sample; when the
    // sum carries out, post becomes DEPTH-1-pre, i.e. the bitwise inverse.
    assign len_sum      = {1'b0, pre_len} + {1'b0, post_len};
    assign post_clamped = len_sum[ADDR_W] ? ~pre_len : post_len;

    assign bps_start = busy;

    la_trig_match #(.DATA_W(DATA_W)) u_trig (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (arm_ok),
        .mask_in (trig_mask),
        .val_in  (trig_val),
        .mode_in (trig_mode),
        .sample  (sample),
        .probe   (probe_in),
        .fire    (fire)
    );

    // Capture FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            pre_l      <= '0;
            post_l     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
        end else begin
            wr.wr_en <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (arm_ok) begin
                pre_l  <= pre_len;
                post_l <= post_clamped;
                ptr    <= '0;
                cnt    <= '0;
                done   <= 1'b0;
                busy   <= 1'b1;
                state  <= (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE;
            end else if (sample) begin
                wr.wr_en   <= 1'b1;
                wr.wr_addr <= ptr;
                wr.wr_data <= probe_in;
                ptr        <= ptr + ONE;
                case (state)
                    ST_PRE: begin
                        if (cnt == pre_l - ONE) begin
                            cnt   <= '0;
                            state <= ST_WAIT_TRIG;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (fire) begin
                            trig_addr  <= ptr;
                            start_addr <= ptr - pre_l;
                            cnt        <= '0;
                            if (post_l == '0) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (cnt == post_l - ONE) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Capture controller for the logic analyser, directly downstream of the sample-clock divider. It drives the divider's enable (`bps_start`) and consumes its one-cycle sample-enable pulse (`clk_bps`). On each pulse it registers the probe bus, writes it into a circular capture RAM and evaluates the trigger condition. It then stops after a programmed number of post-trigger samples and reports where the pre-trigger window starts.

## Interface
- `DATA_W`, 8: probe/sample width.
- `ADDR_W`, 10: capture RAM address width; DEPTH = 2**ADDR_W.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_bps`  in  1  sample-enable pulse from divider, one `clk` wide.
- `bps_start`  out  1  divider enable; high while capture is running.
- `probe_in`  in  DATA_W  probe channels, already synchronised.
- `arm`  in  1  pulse: start a capture.
- `abort`  in  1  pulse: stop the capture immediately.
- `pre_len`  in  ADDR_W  samples required before the trigger is accepted.
- `post_len`  in  ADDR_W  samples stored after the trigger sample.
- `trig_mask`  in  DATA_W  channels taking part in the trigger.
- `trig_val`  in  DATA_W  required value on masked channels.
- `trig_mode`  in  2  00 level, 01 rising match, 10 force, 11 treated as level.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  DATA_W  RAM write data.
- `trig_addr`  out  ADDR_W  address of the trigger sample.
- `start_addr`  out  ADDR_W  equals trig_addr - pre_len (mod DEPTH).
- `busy`  out  1  capture in progress.
- `done`  out  1  capture complete; held until the next `arm` or `abort`.

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- `bps_start` = `busy` = (state is PRE, WAIT_TRIG or POST).
- `arm` in IDLE or DONE, with `abort` low:
  - latches `pre_len`, `post_len`, `trig_mask`, `trig_val` and `trig_mode`;
  - clears the write pointer, sample counter and `done`; sets `prev_match` to 1;
  - next state is PRE, or WAIT_TRIG if pre_len = 0.
- `arm` in any other state is ignored.
- Clamp: if pre_len + post_len >= DEPTH, the latched post_len becomes DEPTH-1-pre_len.
- Per-sample behaviour (only when `clk_bps` = 1 in PRE, WAIT_TRIG or POST; pulses in other states are ignored):
  - `probe_in` is written at the write pointer, then the pointer increments and wraps DEPTH-1 to 0.
  - match = ((probe_in ^ trig_val_l) & trig_mask_l) == 0. `prev_match` takes the new match value on every sample.
- PRE: count samples. After pre_len samples, go to WAIT_TRIG.
- WAIT_TRIG: the trigger fires on the current sample when:
  - mode 00/11: match;
  - mode 01: match && !prev_match;
  - mode 10: any sample.
- On trigger:
  - `trig_addr` takes that sample's address and `start_addr` is updated;
  - if post_len = 0 go to DONE, else go to POST.
- WAIT_TRIG with no trigger overwrites the oldest data around the ring indefinitely.
- POST: count post_len samples, then go to DONE. The transition happens on the final sample.
- DONE: `done` = 1 and no writes occur.
- `abort` (highest priority, any state): go to IDLE. `done` goes to 0 and no write is issued for a coincident `clk_bps`.

## Timing
- Reset values: state IDLE; `bps_start`, `busy`, `done` and `wr_en` are 0; `wr_addr`, `wr_data`, `trig_addr` and `start_addr` are 0.
- Write latency:
  - `clk_bps` at cycle N gives `wr_en` = 1 for exactly one cycle at N+1;
  - `wr_data` is `probe_in` registered at N;
  - `wr_addr` is the pointer value at N.
- Trigger outputs: `trig_addr` and `start_addr` are valid from N+1 when the trigger sample is at N.
- `done`:
  - rises at N+1 after the last stored sample, in the same cycle as that sample's `wr_en`;
  - `bps_start` falls in the same cycle.
- `arm` at cycle N gives `bps_start` = 1 from N+1. `clk_bps` at N+1 is the first sample.
- Reset mid-capture: all outputs return to their reset values immediately (asynchronous).
- `wr_en` is always registered; it is never combinational from `clk_bps`.

## Structure
- Package `la_pkg`:
  - state enum for the five states;
  - trigger-mode constants (TRIG_LEVEL = 2'b00, TRIG_RISE = 2'b01, TRIG_FORCE = 2'b10).
- One sub-module, `la_trig_match`: holds the latched mask/value, computes match, registers `prev_match`, and outputs `fire` for the current mode. The FSM, counters and write path stay in `la_capture_ctrl`.

## Test plan
All scenarios use ADDR_W = 4 and DATA_W = 8.
- Level trigger:
  - stimulus: pre_len = 3, post_len = 4, mask = 0xFF, val = 0x5A, probe counts 0x50, 0x51, … per pulse;
  - required: trigger on 0x5A at addr 10, trig_addr = 10, start_addr = 7;
  - required: 15 writes total, done after the write of 0x5E at addr 14.
- Rising-match mode:
  - stimulus: mask = 0x01, val = 0x01, probe bit0 already high at arm;
  - required: no trigger until bit0 goes 0 then 1;
  - required: trig_addr equals the address of the first 0-to-1 sample.
- Force mode with pre_len = 0, post_len = 0:
  - required: first sample triggers; trig_addr = 0, start_addr = 0;
  - required: one write, done at N+1, bps_start low at N+1.
- Clamp and wrap:
  - stimulus: pre_len = 10, post_len = 12;
  - required: post_len clamps to 5, the write pointer wraps 15 to 0, and no more than 16 samples are written after the trigger.
- Abort and arm rules:
  - stimulus: `abort` coincident with `clk_bps` in POST;
  - required: no wr_en, return to IDLE, done = 0;
  - stimulus: `arm` while busy is ignored;
  - required: `arm` in DONE restarts with wr_addr = 0.
- Reset mid-capture: asserting rst_n = 0 in WAIT_TRIG drops bps_start, busy and wr_en the same cycle.
